// File: rtl/pio_in_capture.sv
// Avalon-MM input PIO: synchronised, debounced inputs with
// sticky edge capture and a masked level interrupt.
module pio_in_capture #(
   parameter int unsigned WIDTH           = 18,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned EDGE_TYPE       = 0,
   parameter int unsigned RESET_VALUE     = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int unsigned DB = (DEBOUNCE_CYCLES == 0) ? 1 : DEBOUNCE_CYCLES;
   localparam int unsigned CW = $clog2(DB + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);
   localparam logic [2:0] PRIME_N = 3'(SYNC_STAGES);
   localparam logic [WIDTH-1:0] MASK_RST = WIDTH'(RESET_VALUE);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] sync_out;
   logic [WIDTH-1:0] sync_nxt;
   logic [WIDTH-1:0] settled_q;
   logic [WIDTH-1:0] settled_d;
   logic [WIDTH-1:0] cap_q;
   logic [WIDTH-1:0] cap_d;
   logic [WIDTH-1:0] cap_set;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] changed;
   logic [WIDTH-1:0] mask_q;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic [2:0]       prime_q;
   logic             priming;
   logic             wr_en;
   logic [31:0]      rd_d;
   logic             unused_ok;

   assign sync_out  = sync_q[SYNC_STAGES-1];
   assign sync_nxt  = sync_q[SYNC_STAGES-2];
   assign priming   = (prime_q < PRIME_N);
   assign wr_en     = chipselect & write;
   assign unused_ok = &{1'b0, writedata};

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      end
   end

   // Priming loads the value sync_out takes on this same edge,
   // so inputs held through reset settle without a false edge.
   always_comb begin
      settled_d = settled_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (!priming && (sync_out[i] != settled_q[i])) begin
            if (cnt_q[i] >= DB_LAST) begin
               settled_d[i] = sync_out[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
      if (priming) begin
         settled_d = sync_nxt;
      end
   end

   always_comb begin
      changed = priming ? '0 : (settled_d ^ settled_q);
      unique case (EDGE_TYPE)
         0:       cap_set = changed & settled_d;
         1:       cap_set = changed & ~settled_d;
         default: cap_set = changed;
      endcase
      cap_clr = '0;
      if (wr_en && (address == 2'd3)) begin
         cap_clr = writedata[WIDTH-1:0];
      end
      cap_d = (cap_q & ~cap_clr) | cap_set;
   end

   always_comb begin
      rd_d = '0;
      unique case (address)
         2'd0: rd_d[WIDTH-1:0] = settled_q;
         2'd1: rd_d = '0;
         2'd2: rd_d[WIDTH-1:0] = mask_q;
         2'd3: rd_d[WIDTH-1:0] = cap_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         settled_q <= '0;
         cap_q     <= '0;
         mask_q    <= MASK_RST;
         prime_q   <= '0;
         readdata  <= '0;
      end else begin
         settled_q <= settled_d;
         cap_q     <= cap_d;
         readdata  <= rd_d;
         if (priming) begin
            prime_q <= prime_q + 3'd1;
         end
         if (wr_en && (address == 2'd2)) begin
            mask_q <= writedata[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (reset) begin
            cnt_q[i] <= '0;
         end else begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_pio_in_capture.sv
// Scoreboard bench for pio_in_capture against a sample-history
// reference model; every cycle's readdata and irq are checked.
module tb_pio_in_capture;

   localparam int W = 18;
   localparam int S = 2;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    address;
   logic          chipselect;
   logic          write;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [W-1:0]  in_port;
   logic          irq;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] rd;
      logic        irq;
   } exp_t;

   exp_t sb[$];

   logic [W-1:0] hist[$];
   logic [W-1:0] m_set;
   logic [W-1:0] m_cap;
   logic [W-1:0] m_mask;
   int           run[W];

   pio_in_capture #(
      .WIDTH(W),
      .SYNC_STAGES(S),
      .DEBOUNCE_CYCLES(D),
      .EDGE_TYPE(0),
      .RESET_VALUE(0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .address(address),
      .chipselect(chipselect),
      .write(write),
      .writedata(writedata),
      .readdata(readdata),
      .in_port(in_port),
      .irq(irq)
   );

   always #5 clk = ~clk;

   // Reference: sync_out before edge n is the sample from edge n-S;
   // settled flips after D consecutive mismatching samples.
   always @(posedge clk) begin : model
      logic [31:0]  rdv;
      logic [W-1:0] sbf;
      logic [W-1:0] saf;
      logic [W-1:0] nset;
      logic [W-1:0] chg;
      logic [W-1:0] clr;
      int           n;
      exp_t         e;
      rdv = '0;
      if (reset) begin
         hist.delete();
         m_set  = '0;
         m_cap  = '0;
         m_mask = '0;
         for (int i = 0; i < W; i++) run[i] = 0;
      end else begin
         case (address)
            2'd0: rdv = 32'(m_set);
            2'd2: rdv = 32'(m_mask);
            2'd3: rdv = 32'(m_cap);
            default: rdv = '0;
         endcase
         hist.push_back(in_port);
         n = hist.size();
         sbf = (n > S) ? hist[n-1-S] : '0;
         saf = (n >= S) ? hist[n-S] : '0;
         nset = m_set;
         chg = '0;
         if (n <= S) begin
            nset = saf;
            for (int i = 0; i < W; i++) run[i] = 0;
         end else begin
            for (int i = 0; i < W; i++) begin
               if (sbf[i] != m_set[i]) begin
                  run[i]++;
                  if (run[i] >= D) begin
                     nset[i] = sbf[i];
                     run[i] = 0;
                  end
               end else begin
                  run[i] = 0;
               end
            end
            chg = nset ^ m_set;
         end
         clr = '0;
         if (chipselect && write && address == 2'd3) clr = writedata[W-1:0];
         m_cap = (m_cap & ~clr) | (chg & nset);
         if (chipselect && write && address == 2'd2) m_mask = writedata[W-1:0];
         m_set = nset;
      end
      e.rd  = rdv;
      e.irq = |(m_cap & m_mask);
      sb.push_back(e);
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard empty at %0t", $time);
         end else begin
            e = sb.pop_front();
            if (readdata !== e.rd) begin
               errors++;
               $display("FAIL readdata got %h want %h at %0t",
                        readdata, e.rd, $time);
            end
            checks++;
            if (irq !== e.irq) begin
               errors++;
               $display("FAIL irq got %b want %b at %0t",
                        irq, e.irq, $time);
            end
         end
      end
   end

   task automatic step(int k = 1);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write      = 1'b1;
      address    = a;
      writedata  = d;
      step();
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   initial begin
      reset      = 1'b1;
      address    = 2'd0;
      chipselect = 1'b0;
      write      = 1'b0;
      writedata  = '0;
      in_port    = 18'h3FFFF;
      step(3);
      // inputs high through reset release
      reset = 1'b0;
      step(6);
      address = 2'd3;
      step(4);
      in_port = '0;
      address = 2'd0;
      step(10);
      // reset mid-debounce
      in_port = 18'h00001;
      step(S + 2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      in_port = '0;
      step(12);
      wr(2'd2, 32'hFFFF_FFFF);
      wr(2'd3, 32'hFFFF_FFFF);
      address = 2'd3;
      // glitch of 3, then pulse of 4
      in_port = 18'h00008;
      step(3);
      in_port = '0;
      step(10);
      in_port = 18'h00008;
      step(4);
      in_port = '0;
      step(10);
      // capture set vs clear on the same edge
      in_port = 18'h00001;
      step(S + D - 1);
      wr(2'd3, 32'h1);
      address = 2'd3;
      step(3);
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0)
            in_port = in_port ^ W'(1 << $urandom_range(0, W-1));
         address    = 2'($urandom_range(0, 3));
         chipselect = ($urandom_range(0, 4) == 0);
         write      = $urandom_range(0, 1) == 1;
         writedata  = $urandom;
         reset      = ($urandom_range(0, 599) == 0);
         step();
      end
      reset      = 1'b0;
      chipselect = 1'b0;
      write      = 1'b0;
      step(2);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
